pc_stack_unit: RTL and testbench

Parametrised program-counter unit for the accumulator datapath. It generalises the 16-bit PC to a configurable address width, uses an encoded branch-condition field in place of the beq/bne select, and adds a hardware return-address stack for call/return. It sits between the control unit and instruction memory and drives the instruction fetch address.

---
 rtl/pc_pkg.sv | 19 +
 rtl/ret_stack.sv | 57 +++++
 rtl/pc_stack_unit.sv | 80 ++++++++
 tb/tb_pc_stack_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit:
// branch-condition and next-PC source codes.
package pc_pkg;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_AL = 2'b10,
    BR_NV = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_IMM = 2'b01,
    SRC_REG = 2'b10,
    SRC_RET = 2'b11
  } pc_src_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with sticky overflow/underflow flag.
// A simultaneous push and pop replaces the top entry in place.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    dm1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             fault_now;

  assign empty   = (depth == '0);
  assign full    = (depth == DW'(DEPTH));
  assign dm1     = depth - DW'(1);
  assign top_idx = dm1[AW-1:0];
  assign top     = mem[top_idx];

  // swap writes over the old top; plain push writes one above it
  assign wr_en  = push & (pop ? ~empty : ~full);
  assign wr_idx = pop ? top_idx : depth[AW-1:0];

  assign fault_now = (pop & empty) | (push & ~pop & full);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (fault_now) err <= 1'b1;
      if (push & ~pop & ~full)
        depth <= depth + DW'(1);
      else if (pop & ~push & ~empty)
        depth <= dm1;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with condition decode, source mux
// and a hardware return-address stack for call/return.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int              DW        = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [1:0]       BrCond,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] PCInA,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] PCInC,
  input  logic             Call,
  output logic [WIDTH-1:0] PCOut,
  output logic [DW-1:0]    StackDepth,
  output logic             StackEmpty,
  output logic             StackFull,
  output logic             Fault
);

  logic             cond;
  logic             en;
  logic             is_ret;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next_pc;

  always_comb begin
    cond = 1'b0;
    unique case (br_cond_e'(BrCond))
      BR_EQ: cond = Zero;
      BR_NE: cond = ~Zero;
      BR_AL: cond = 1'b1;
      BR_NV: cond = 1'b0;
    endcase
  end

  assign en     = PCWrite | (Branch & cond);
  assign is_ret = (pc_src_e'(PCSrc) == SRC_RET);

  // a return from an empty stack leaves the PC where it is
  always_comb begin
    next_pc = PCInA;
    unique case (pc_src_e'(PCSrc))
      SRC_SEQ: next_pc = PCInA;
      SRC_IMM: next_pc = {Imm[WIDTH-2:0], 1'b0};
      SRC_REG: next_pc = PCInC;
      SRC_RET: next_pc = StackEmpty ? PCOut : top;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset)   PCOut <= RESET_VEC;
    else if (en) PCOut <= next_pc;
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (CLK),
    .rst   (reset),
    .push  (en & Call),
    .pop   (en & is_ret),
    .din   (PCInA),
    .top   (top),
    .depth (StackDepth),
    .full  (StackFull),
    .empty (StackEmpty),
    .err   (Fault)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed walk-through
// plus randomized traffic against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] RV = 16'h0000;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             PCWrite = 1'b0;
  logic             Branch = 1'b0;
  logic             Zero = 1'b0;
  logic [1:0]       BrCond = 2'b00;
  logic [1:0]       PCSrc = 2'b00;
  logic [WIDTH-1:0] PCInA = '0;
  logic [WIDTH-1:0] Imm = '0;
  logic [WIDTH-1:0] PCInC = '0;
  logic             Call = 1'b0;
  logic [WIDTH-1:0] PCOut;
  logic [DW-1:0]    StackDepth;
  logic             StackEmpty;
  logic             StackFull;
  logic             Fault;

  pc_stack_unit #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .Zero       (Zero),
    .BrCond     (BrCond),
    .PCSrc      (PCSrc),
    .PCInA      (PCInA),
    .Imm        (Imm),
    .PCInC      (PCInC),
    .Call       (Call),
    .PCOut      (PCOut),
    .StackDepth (StackDepth),
    .StackEmpty (StackEmpty),
    .StackFull  (StackFull),
    .Fault      (Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             fault;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [WIDTH-1:0] m_pc = RV;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_fault = 1'b0;

  function automatic void model_step();
    logic c;
    logic [WIDTH-1:0] t;
    exp_t e;
    case (BrCond)
      2'b00:   c = Zero;
      2'b01:   c = !Zero;
      2'b10:   c = 1'b1;
      default: c = 1'b0;
    endcase
    if (reset) begin
      m_pc = RV;
      m_stk.delete();
      m_fault = 1'b0;
    end else if (PCWrite || (Branch && c)) begin
      if (PCSrc == 2'b11) begin
        if (m_stk.size() == 0) begin
          m_fault = 1'b1;
        end else begin
          t = m_stk[m_stk.size()-1];
          m_pc = t;
          if (Call) m_stk[m_stk.size()-1] = PCInA;
          else void'(m_stk.pop_back());
        end
      end else begin
        case (PCSrc)
          2'b00:   m_pc = PCInA;
          2'b01:   m_pc = Imm << 1;
          default: m_pc = PCInC;
        endcase
        if (Call) begin
          if (m_stk.size() == DEPTH) m_fault = 1'b1;
          else m_stk.push_back(PCInA);
        end
      end
    end
    e.pc    = m_pc;
    e.depth = DW'(m_stk.size());
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.fault = m_fault;
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic rs, input logic pw, input logic br,
                      input logic z, input logic [1:0] bc,
                      input logic [1:0] src, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] im, input logic [WIDTH-1:0] rc,
                      input logic cl);
    reset = rs; PCWrite = pw; Branch = br; Zero = z; BrCond = bc;
    PCSrc = src; PCInA = a; Imm = im; PCInC = rc; Call = cl;
    @(posedge CLK);
    model_step();
    #1;
    reset = 1'b0; PCWrite = 1'b0; Branch = 1'b0; Call = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc",    32'(PCOut),      32'(e.pc));
      chk("depth", 32'(StackDepth), 32'(e.depth));
      chk("empty", 32'(StackEmpty), 32'(e.empty));
      chk("full",  32'(StackFull),  32'(e.full));
      chk("fault", 32'(Fault),      32'(e.fault));
    end
  end

  initial begin
    int n;
    // reset and sequential update
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 16'h0002, 0, 0, 0);
    // branch conditions
    step(0, 0, 1, 0, 2'b00, 2'b01, 0, 16'h0010, 0, 0);
    step(0, 0, 1, 1, 2'b00, 2'b01, 0, 16'h0010, 0, 0);
    step(0, 0, 1, 1, 2'b01, 2'b01, 0, 16'h0030, 0, 0);
    step(0, 0, 1, 0, 2'b01, 2'b01, 0, 16'h0030, 0, 0);
    step(0, 0, 1, 0, 2'b11, 2'b01, 0, 16'h0050, 0, 0);
    step(0, 0, 1, 1, 2'b10, 2'b01, 0, 16'h8001, 0, 0);
    // call / return
    step(0, 1, 0, 0, 0, 2'b10, 16'h0102, 0, 16'h0400, 1);
    step(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    // fill, overflow, drain
    for (int i = 0; i <= DEPTH; i++)
      step(0, 1, 0, 0, 0, 2'b00, 16'(16'h0010 + 2 * i), 0, 0, 1);
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    // underflow with a known PC
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'b00, 16'h0044, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'b00, 16'h0046, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // swap on top, then reset mid-sequence
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'b00, 16'h0100, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2'b00, 16'h0200, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2'b11, 16'h0300, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 2'b10, 16'h0500, 0, 16'h0600, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 99);
      step(n == 0, $urandom_range(0, 2) != 0, 1'($urandom),
           1'($urandom), 2'($urandom), 2'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 2) == 0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge CLK);
      n++;
    end
    @(posedge CLK);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
